imm_materialise: RTL

- Inverse of the decode-side immediate extender.
- Takes a 32-bit constant and a destination register, and emits the minimal RV32I instruction sequence that rebuilds that constant in the register.
- Sequence is one of: ADDI; LUI; or LUI followed by ADDI.
- Used by the boot/debug instruction injector to feed constant-load instructions into fetch over a valid/ready stream.

---
 rtl/imm_materialise.sv | 130 +++++++++++++
 1 files changed

// File: rtl/imm_materialise.sv
// rtl/imm_materialise.sv - emits the minimal RV32I ADDI/LUI sequence that loads a 32-bit constant into rd
// Requests are taken only in IDLE. The instruction word and last flag are registered outputs.

module imm_materialise #(
  parameter logic OPT_LUI_ONLY = 1'b1,
  parameter logic OPT_RD0_NOP  = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_value,
  input  logic [4:0]  in_rd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_last,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    EMIT_LUI  = 2'd1,
    EMIT_ADDI = 2'd2
  } state_e;

  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
  localparam logic [6:0]  OPC_OP_IMM  = 7'b0010011;
  localparam logic [6:0]  OPC_LUI     = 7'b0110111;

  state_e      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic        last_q, last_d;
  logic [31:0] pend_q, pend_d;

  logic [19:0] hi20;
  logic [11:0] lo12;
  logic        fits12;

  function automatic logic [31:0] enc_addi(input logic [4:0] rd, input logic [4:0] rs1,
                                           input logic [11:0] imm);
    enc_addi = {imm, rs1, 3'b000, rd, OPC_OP_IMM};
  endfunction

  function automatic logic [31:0] enc_lui(input logic [4:0] rd, input logic [19:0] imm);
    enc_lui = {imm, rd, OPC_LUI};
  endfunction

  // (value + 0x800) >> 12 reduces to adding bit 11 into the upper 20 bits; wrap is intended.
  assign hi20   = in_value[31:12] + {19'd0, in_value[11]};
  assign lo12   = in_value[11:0];
  assign fits12 = (in_value[31:11] == 21'h000000) || (in_value[31:11] == 21'h1FFFFF);

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    last_d  = last_q;
    pend_d  = pend_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if ((in_rd == 5'd0) && OPT_RD0_NOP) begin
            state_d = EMIT_ADDI;
            instr_d = NOP_INSTR;
            last_d  = 1'b1;
          end else if (fits12) begin
            state_d = EMIT_ADDI;
            instr_d = enc_addi(in_rd, 5'd0, lo12);
            last_d  = 1'b1;
          end else if ((lo12 == 12'd0) && OPT_LUI_ONLY) begin
            state_d = EMIT_LUI;
            instr_d = enc_lui(in_rd, in_value[31:12]);
            last_d  = 1'b1;
          end else begin
            state_d = EMIT_LUI;
            instr_d = enc_lui(in_rd, hi20);
            last_d  = 1'b0;
            pend_d  = enc_addi(in_rd, in_rd, lo12);
          end
        end
      end
      EMIT_LUI: begin
        if (out_ready) begin
          if (last_q) begin
            state_d = IDLE;
            instr_d = 32'd0;
            last_d  = 1'b0;
          end else begin
            state_d = EMIT_ADDI;
            instr_d = pend_q;
            last_d  = 1'b1;
          end
        end
      end
      EMIT_ADDI: begin
        if (out_ready) begin
          state_d = IDLE;
          instr_d = 32'd0;
          last_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        instr_d = 32'd0;
        last_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      instr_q <= 32'd0;
      last_q  <= 1'b0;
      pend_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      last_q  <= last_d;
      pend_q  <= pend_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == EMIT_LUI) || (state_q == EMIT_ADDI);
  assign busy      = (state_q != IDLE);
  assign out_instr = instr_q;
  assign out_last  = last_q;

endmodule
